dma_chan_reg_loader: RTL and testbench
======================================

Name: dma_chan_reg_loader

Overview:
- Multi-channel DMA register loader: assembles multi-byte address and word-count values from the 8-bit data bus into per-channel base and current registers.
- Also advances the current registers on each transfer step and flags terminal count.
- Sits between the CPU-side bus decoder and the DMA transfer FSM.
- Parametrised in channel count and register width; replaces the single-channel, 16-bit, level-sensitive byte concatenator.

Parameters:
- NUM_CH, 4, number of DMA channels (1..8)
- REG_BYTES, 2, bytes per address/count register; register width REG_W = 8*REG_BYTES (1..4)
- CH_W, 2, width of channel select, = clog2(NUM_CH) (min 1)

Ports:
- clk  in  1  rising-edge clock
- RESET  in  1  reset, asynchronous, active-high
- wr_en  in  1  byte write strobe, sampled on clk
- wr_ch  in  CH_W  target channel of the byte write
- wr_reg  in  1  target register: 0 = address, 1 = word count
- data_bus  in  8  write data byte
- clear_ff  in  1  synchronous clear of the byte pointer and staging register
- step_en  in  1  transfer-step request from the transfer FSM
- step_ch  in  CH_W  channel being stepped
- cur_addr  out  NUM_CH*REG_W  current address per channel, ch0 in the LSBs
- cur_count  out  NUM_CH*REG_W  current word count per channel
- base_addr  out  NUM_CH*REG_W  base address per channel
- base_count  out  NUM_CH*REG_W  base word count per channel
- tc  out  NUM_CH  terminal-count flag per channel
- load_done  out  1  one-cycle pulse: a register was committed
- byte_ptr  out  2  index of the next expected byte (0 = first)

Behaviour:
- Reset (async, RESET high):
  - all base/current registers = 0; tc = 0; load_done = 0; byte_ptr = 0
  - staging register = 0; latched target = ch0/addr
- Byte assembly (clocked; replaces the level-sensitive scheme):
  - Each clk edge with wr_en=1 shifts data_bus into the staging register. Order is MSB first: staging <= {staging[REG_W-9:0], data_bus}.
  - Byte 0 also latches the target (wr_ch, wr_reg).
  - Byte index REG_BYTES-1 commits: the staging value concatenated with this byte is written to both base and current of the target at that same edge. byte_ptr returns to 0. load_done = 1 for the next cycle only.
  - Target change mid-sequence (wr_ch/wr_reg differs from latched target while byte_ptr != 0): the partial is discarded, the byte is treated as byte 0 of the new target, and no commit to the old target occurs.
  - REG_BYTES = 1: every write commits immediately.
  - wr_ch >= NUM_CH: byte is ignored and byte_ptr is unchanged.
  - clear_ff=1: byte_ptr = 0 and staging = 0. If wr_en is also high in the same cycle, clear_ff wins and the byte is dropped.
- Commit to a count register clears tc of that channel.
- Step (step_en=1, step_ch valid):
  - If cur_count[ch] != 0: cur_addr += 1 (wraps modulo 2^REG_W) and cur_count -= 1.
  - If cur_count was 1 before the step, tc[ch] is set.
  - If cur_count == 0: no register change; tc unchanged.
- tc is sticky until a count commit on that channel or RESET.
- Step and commit on the same channel in the same cycle: the commit wins and the step is lost for that channel. Other channels are unaffected.
- Base registers change only on commit.

Optional Feature:
- Macro: DMA_AUTOINIT_EN.
- When defined:
  - Adds input autoinit (NUM_CH bits).
  - A step that takes cur_count from 1 to 0 on a channel with autoinit set reloads cur_addr and cur_count from base at that edge.
  - tc for that channel is a single-cycle pulse, not sticky.
- When undefined: the port is absent; counters stop at 0 and tc is sticky as above.

Test Plan:
- Reset then write ch1/addr bytes 0x12, 0x34 -> base_addr[1] = cur_addr[1] = 0x1234; load_done high exactly 1 cycle after the second byte; byte_ptr 0.
- Write ch0/count byte 0xAB, then ch2/addr bytes 0x56, 0x78 -> ch0 count stays 0; ch2 addr = 0x5678; exactly one load_done pulse.
- Load ch3 count 0x0002, addr 0xFFFF; step ch3 twice -> addr 0x0000 then 0x0001; count 1 then 0; tc[3] set on second step; third step causes no change.
- Write first byte 0x99 to ch0/addr, assert clear_ff, write 0x11, 0x22 -> cur_addr[0] = 0x1122.
- Same cycle: final count byte commit to ch1 plus step_en on ch1 -> cur_count[1] = committed value, tc[1] = 0; assert RESET mid-sequence -> all outputs 0 immediately.
- DMA_AUTOINIT_EN, autoinit[0]=1, base count 1, base addr 0x0100: one step -> tc[0] pulses 1 cycle; cur_addr[0] = 0x0100, cur_count[0] = 1.

Source files
------------

// File: rtl/dma_chan_reg_loader_if.sv
// Bus bundle for dma_chan_reg_loader: CPU byte-write path, transfer-step requests and
// per-channel register outputs. The autoinit vector exists only with DMA_AUTOINIT_EN.
interface dma_chan_reg_loader_if #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned REG_BYTES = 2,
    parameter int unsigned CH_W      = 2
);
    localparam int unsigned REG_W = 8 * REG_BYTES;

    logic                    wr_en;
    logic [CH_W-1:0]         wr_ch;
    logic                    wr_reg;
    logic [7:0]              data_bus;
    logic                    clear_ff;
    logic                    step_en;
    logic [CH_W-1:0]         step_ch;
`ifdef DMA_AUTOINIT_EN
    logic [NUM_CH-1:0]       autoinit;
`endif
    logic [NUM_CH*REG_W-1:0] cur_addr;
    logic [NUM_CH*REG_W-1:0] cur_count;
    logic [NUM_CH*REG_W-1:0] base_addr;
    logic [NUM_CH*REG_W-1:0] base_count;
    logic [NUM_CH-1:0]       tc;
    logic                    load_done;
    logic [1:0]              byte_ptr;

    modport master (
        output wr_en, wr_ch, wr_reg, data_bus, clear_ff, step_en, step_ch,
`ifdef DMA_AUTOINIT_EN
        output autoinit,
`endif
        input  cur_addr, cur_count, base_addr, base_count, tc, load_done, byte_ptr
    );

    modport slave (
        input  wr_en, wr_ch, wr_reg, data_bus, clear_ff, step_en, step_ch,
`ifdef DMA_AUTOINIT_EN
        input  autoinit,
`endif
        output cur_addr, cur_count, base_addr, base_count, tc, load_done, byte_ptr
    );
endinterface

// File: rtl/dma_chan_reg_loader.sv
// Multi-channel DMA register loader: clocked MSB-first byte assembly into base/current
// registers, per-channel stepping and terminal count. Optional feature: DMA_AUTOINIT_EN.
module dma_chan_reg_loader #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned REG_BYTES = 2,
    parameter int unsigned CH_W      = 2
) (
    input logic                  clk,
    input logic                  RESET,
    dma_chan_reg_loader_if.slave bus
);
    localparam int unsigned REG_W = 8 * REG_BYTES;

    logic [REG_W-1:0] stage_q, stage_d, stage_next;
    logic [1:0]       ptr_q, ptr_d, eff_ptr;
    logic [CH_W-1:0]  tgt_ch_q, tgt_ch_d;
    logic             tgt_reg_q, tgt_reg_d;
    logic             done_q;
    logic             wr_valid, restart, commit;

    assign stage_next = REG_W'({stage_q, bus.data_bus});
    assign wr_valid   = bus.wr_en && !bus.clear_ff && (32'(bus.wr_ch) < NUM_CH);
    // A byte for a different target while mid-sequence restarts assembly at byte 0.
    assign restart    = (ptr_q != 2'd0) && ((bus.wr_ch != tgt_ch_q) || (bus.wr_reg != tgt_reg_q));
    assign eff_ptr    = restart ? 2'd0 : ptr_q;
    assign commit     = wr_valid && (32'(eff_ptr) == REG_BYTES - 1);

    always_comb begin
        stage_d   = stage_q;
        ptr_d     = ptr_q;
        tgt_ch_d  = tgt_ch_q;
        tgt_reg_d = tgt_reg_q;
        if (bus.clear_ff) begin
            stage_d = '0;
            ptr_d   = 2'd0;
        end else if (wr_valid) begin
            stage_d = stage_next;
            if (eff_ptr == 2'd0) begin
                tgt_ch_d  = bus.wr_ch;
                tgt_reg_d = bus.wr_reg;
            end
            ptr_d = commit ? 2'd0 : eff_ptr + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            stage_q   <= '0;
            ptr_q     <= 2'd0;
            tgt_ch_q  <= '0;
            tgt_reg_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            ptr_q     <= ptr_d;
            tgt_ch_q  <= tgt_ch_d;
            tgt_reg_q <= tgt_reg_d;
            done_q    <= commit;
        end
    end

    assign bus.load_done = done_q;
    assign bus.byte_ptr  = ptr_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [REG_W-1:0] cur_addr_q, cur_addr_d, cur_count_q, cur_count_d;
        logic [REG_W-1:0] base_addr_q, base_addr_d, base_count_q, base_count_d;
        logic             tc_q, tc_d, hit_commit, hit_step;

        assign hit_commit = commit && (bus.wr_ch == CH_W'(c));
        // A commit to this channel swallows a coincident step.
        assign hit_step   = bus.step_en && (bus.step_ch == CH_W'(c)) && !hit_commit
                            && (cur_count_q != '0);

        always_comb begin
            cur_addr_d   = cur_addr_q;
            cur_count_d  = cur_count_q;
            base_addr_d  = base_addr_q;
            base_count_d = base_count_q;
            tc_d         = tc_q;
`ifdef DMA_AUTOINIT_EN
            if (bus.autoinit[c]) tc_d = 1'b0;
`endif
            if (hit_commit) begin
                if (bus.wr_reg) begin
                    base_count_d = stage_next;
                    cur_count_d  = stage_next;
                    tc_d         = 1'b0;
                end else begin
                    base_addr_d = stage_next;
                    cur_addr_d  = stage_next;
                end
            end else if (hit_step) begin
                cur_addr_d  = cur_addr_q + REG_W'(1);
                cur_count_d = cur_count_q - REG_W'(1);
                if (cur_count_q == REG_W'(1)) begin
                    tc_d = 1'b1;
`ifdef DMA_AUTOINIT_EN
                    if (bus.autoinit[c]) begin
                        cur_addr_d  = base_addr_q;
                        cur_count_d = base_count_q;
                    end
`endif
                end
            end
        end

        always_ff @(posedge clk or posedge RESET) begin
            if (RESET) begin
                cur_addr_q   <= '0;
                cur_count_q  <= '0;
                base_addr_q  <= '0;
                base_count_q <= '0;
                tc_q         <= 1'b0;
            end else begin
                cur_addr_q   <= cur_addr_d;
                cur_count_q  <= cur_count_d;
                base_addr_q  <= base_addr_d;
                base_count_q <= base_count_d;
                tc_q         <= tc_d;
            end
        end

        assign bus.cur_addr[c*REG_W +: REG_W]   = cur_addr_q;
        assign bus.cur_count[c*REG_W +: REG_W]  = cur_count_q;
        assign bus.base_addr[c*REG_W +: REG_W]  = base_addr_q;
        assign bus.base_count[c*REG_W +: REG_W] = base_count_q;
        assign bus.tc[c]                        = tc_q;
    end
endmodule

// File: tb/tb_dma_chan_reg_loader.sv
// Self-checking bench for dma_chan_reg_loader: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_dma_chan_reg_loader;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned REG_BYTES = 2;
    localparam int unsigned CH_W      = 2;
    localparam int unsigned REG_W     = 8 * REG_BYTES;

    logic clk   = 1'b0;
    logic RESET = 1'b1;
    always #5 clk = ~clk;

    dma_chan_reg_loader_if #(.NUM_CH(NUM_CH), .REG_BYTES(REG_BYTES), .CH_W(CH_W)) bus ();

    dma_chan_reg_loader #(.NUM_CH(NUM_CH), .REG_BYTES(REG_BYTES), .CH_W(CH_W)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [NUM_CH-1:0][REG_W-1:0] m_cur_addr, m_cur_count, m_base_addr, m_base_count;
    logic [NUM_CH-1:0]            m_tc;
    logic                         m_done;
    logic [7:0]                   pend[$];
    int                           p_ch;
    bit                           p_reg;
    logic [NUM_CH-1:0]            ai = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_cur_addr = '0; m_cur_count = '0; m_base_addr = '0; m_base_count = '0;
        m_tc = '0; m_done = 1'b0; pend.delete(); p_ch = 0; p_reg = 1'b0;
    endtask

    task automatic model_edge(input bit we, input int ch, input bit rg, input logic [7:0] d,
                              input bit clr, input bit se, input int sc);
        bit               cm  = 1'b0;
        int               cc  = -1;
        logic [REG_W-1:0] val = '0;
        for (int c = 0; c < NUM_CH; c++) if (ai[c]) m_tc[c] = 1'b0;
        if (clr) pend.delete();
        else if (we && ch < NUM_CH) begin
            if (pend.size() > 0 && (ch != p_ch || rg != p_reg)) pend.delete();
            if (pend.size() == 0) begin p_ch = ch; p_reg = rg; end
            pend.push_back(d);
            if (pend.size() == REG_BYTES) begin
                foreach (pend[i]) val = (val << 8) | REG_W'(pend[i]);
                cm = 1'b1; cc = ch; pend.delete();
            end
        end
        if (se && sc < NUM_CH && sc != cc && m_cur_count[sc] != 0) begin
            m_cur_addr[sc]  = m_cur_addr[sc] + 1;
            m_cur_count[sc] = m_cur_count[sc] - 1;
            if (m_cur_count[sc] == 0) begin
                m_tc[sc] = 1'b1;
                if (ai[sc]) begin
                    m_cur_addr[sc]  = m_base_addr[sc];
                    m_cur_count[sc] = m_base_count[sc];
                end
            end
        end
        if (cm) begin
            if (rg) begin
                m_base_count[cc] = val; m_cur_count[cc] = val; m_tc[cc] = 1'b0;
            end else begin
                m_base_addr[cc] = val; m_cur_addr[cc] = val;
            end
        end
        m_done = cm;
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".cur_addr"},   bus.cur_addr,   m_cur_addr);
        check_val({tag, ".cur_count"},  bus.cur_count,  m_cur_count);
        check_val({tag, ".base_addr"},  bus.base_addr,  m_base_addr);
        check_val({tag, ".base_count"}, bus.base_count, m_base_count);
        check_val({tag, ".tc"},         64'(bus.tc),    64'(m_tc));
        check_val({tag, ".load_done"},  64'(bus.load_done), 64'(m_done));
        check_val({tag, ".byte_ptr"},   64'(bus.byte_ptr),  64'(pend.size()));
    endtask

    task automatic tick(input string tag, input bit we, input int ch, input bit rg,
                        input logic [7:0] d, input bit clr, input bit se, input int sc);
        @(negedge clk);
        bus.wr_en = we; bus.wr_ch = CH_W'(ch); bus.wr_reg = rg; bus.data_bus = d;
        bus.clear_ff = clr; bus.step_en = se; bus.step_ch = CH_W'(sc);
`ifdef DMA_AUTOINIT_EN
        bus.autoinit = ai;
`endif
        model_edge(we, ch, rg, d, clr, se, sc);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        tick(tag, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_reg = 1'b0; bus.data_bus = '0;
        bus.clear_ff = 1'b0; bus.step_en = 1'b0; bus.step_ch = '0;
`ifdef DMA_AUTOINIT_EN
        bus.autoinit = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        RESET = 1'b0;

        // ch1 address load, then load_done must fall after one cycle
        tick("a1_b0", 1, 1, 0, 8'h12, 0, 0, 0);
        tick("a1_b1", 1, 1, 0, 8'h34, 0, 0, 0);
        check_val("ch1_addr", 64'(bus.cur_addr[31:16]), 64'h1234);
        check_val("ch1_done", 64'(bus.load_done), 64'h1);
        idle("a1_idle");
        check_val("ch1_done_low", 64'(bus.load_done), 64'h0);

        // target change mid-sequence discards the ch0 count partial
        tick("sw_b0", 1, 0, 1, 8'hAB, 0, 0, 0);
        tick("sw_b1", 1, 2, 0, 8'h56, 0, 0, 0);
        tick("sw_b2", 1, 2, 0, 8'h78, 0, 0, 0);
        check_val("ch0_count", 64'(bus.cur_count[15:0]), 64'h0);
        check_val("ch2_addr", 64'(bus.cur_addr[47:32]), 64'h5678);
        idle("sw_idle");

        // ch3 stepping across the address wrap to terminal count
        tick("c3_b0", 1, 3, 1, 8'h00, 0, 0, 0);
        tick("c3_b1", 1, 3, 1, 8'h02, 0, 0, 0);
        tick("a3_b0", 1, 3, 0, 8'hFF, 0, 0, 0);
        tick("a3_b1", 1, 3, 0, 8'hFF, 0, 0, 0);
        tick("s3_1", 0, 0, 0, 8'h00, 0, 1, 3);
        check_val("ch3_wrap", 64'(bus.cur_addr[63:48]), 64'h0000);
        tick("s3_2", 0, 0, 0, 8'h00, 0, 1, 3);
        check_val("ch3_tc", 64'(bus.tc[3]), 64'h1);
        check_val("ch3_count0", 64'(bus.cur_count[63:48]), 64'h0);
        tick("s3_3", 0, 0, 0, 8'h00, 0, 1, 3);
        check_val("ch3_hold", 64'(bus.cur_addr[63:48]), 64'h0001);

        // clear_ff drops the partial and wins over a coincident byte
        tick("cl_b0", 1, 0, 0, 8'h99, 0, 0, 0);
        tick("cl_clr", 1, 0, 0, 8'h55, 1, 0, 0);
        tick("cl_b1", 1, 0, 0, 8'h11, 0, 0, 0);
        tick("cl_b2", 1, 0, 0, 8'h22, 0, 0, 0);
        check_val("ch0_addr", 64'(bus.cur_addr[15:0]), 64'h1122);

        // commit beats a same-cycle step and clears the sticky tc
        tick("tc1_b0", 1, 1, 1, 8'h00, 0, 0, 0);
        tick("tc1_b1", 1, 1, 1, 8'h01, 0, 0, 0);
        tick("tc1_s", 0, 0, 0, 8'h00, 0, 1, 1);
        check_val("ch1_tc_set", 64'(bus.tc[1]), 64'h1);
        tick("cs_b0", 1, 1, 1, 8'h00, 0, 0, 0);
        tick("cs_b1", 1, 1, 1, 8'h05, 0, 1, 1);
        check_val("ch1_commit_wins", 64'(bus.cur_count[31:16]), 64'h0005);
        check_val("ch1_tc_clr", 64'(bus.tc[1]), 64'h0);

        // asynchronous reset mid-sequence
        tick("rs_b0", 1, 2, 1, 8'h42, 0, 0, 0);
        @(negedge clk);
        bus.wr_en = 1'b0; bus.step_en = 1'b0;
        RESET = 1'b1;
        #1;
        check_val("rst_cur_addr", bus.cur_addr, 64'h0);
        check_val("rst_cur_count", bus.cur_count, 64'h0);
        check_val("rst_base", bus.base_addr | bus.base_count, 64'h0);
        check_val("rst_misc", {61'h0, bus.load_done, bus.byte_ptr}, 64'h0);
        check_val("rst_tc", 64'(bus.tc), 64'h0);
        model_reset();
        @(negedge clk);
        RESET = 1'b0;
        idle("rst_idle");

`ifdef DMA_AUTOINIT_EN
        ai = 4'b0001;
        tick("ai_c0", 1, 0, 1, 8'h00, 0, 0, 0);
        tick("ai_c1", 1, 0, 1, 8'h01, 0, 0, 0);
        tick("ai_a0", 1, 0, 0, 8'h01, 0, 0, 0);
        tick("ai_a1", 1, 0, 0, 8'h00, 0, 0, 0);
        tick("ai_step", 0, 0, 0, 8'h00, 0, 1, 0);
        check_val("ai_tc", 64'(bus.tc[0]), 64'h1);
        check_val("ai_addr", 64'(bus.cur_addr[15:0]), 64'h0100);
        check_val("ai_count", 64'(bus.cur_count[15:0]), 64'h0001);
        idle("ai_idle");
        check_val("ai_tc_pulse", 64'(bus.tc[0]), 64'h0);
`endif

        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            case ($urandom % 4)
                0, 1:    d = 8'h00;
                2:       d = 8'($urandom % 4);
                default: d = 8'($urandom);
            endcase
`ifdef DMA_AUTOINIT_EN
            if (i % 50 == 0) ai = NUM_CH'($urandom);
`endif
            tick("rand", ($urandom % 3) != 0, int'($urandom % NUM_CH), 1'($urandom), d,
                 ($urandom % 20) == 0, 1'($urandom), int'($urandom % NUM_CH));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
